// File: rtl/ram_port_arbiter.sv
// Shares the single-port RAM between BIOS loader (B), CPU fetch (I)
// and CPU load/store (D); B owns RAM before boot, I/D round-robin after.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 16384
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    booted,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic [ADDR_WIDTH-3:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [15:0]             o_conflict_cnt
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_BYTES);

  typedef enum logic [1:0] {
    P_NONE,
    P_B,
    P_I,
    P_D
  } port_e;

  port_e                 w_sel;
  port_e                 r_tag_port;
  logic                  r_tag_we;
  logic                  r_tag_oor;
  logic                  r_last_i;
  logic [15:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_b_hold;
  logic [DATA_WIDTH-1:0] r_i_hold;
  logic [DATA_WIDTH-1:0] r_d_hold;

  logic                  w_b_elig;
  logic                  w_i_elig;
  logic                  w_d_elig;
  logic                  w_we;
  logic [BW-1:0]         w_be;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_gnt;
  logic                  w_inr;
  logic                  w_rsp_rd;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_val;

  assign w_b_elig = b_req & ~booted;
  assign w_i_elig = i_req & booted;
  assign w_d_elig = d_req & booted;

  // r_last_i=0 means D won last, so I takes the next tie
  always_comb begin
    w_sel = P_NONE;
    if (rst)
      w_sel = P_NONE;
    else if (w_b_elig)
      w_sel = P_B;
    else if (w_i_elig && w_d_elig)
      w_sel = r_last_i ? P_D : P_I;
    else if (w_i_elig)
      w_sel = P_I;
    else if (w_d_elig)
      w_sel = P_D;
  end

  always_comb begin
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = b_addr;
    w_wdata = b_wdata;
    case (w_sel)
      P_B: begin
        w_we    = b_we;
        w_be    = b_be;
        w_addr  = b_addr;
        w_wdata = b_wdata;
      end
      P_I: begin
        w_we    = i_we;
        w_be    = i_be;
        w_addr  = i_addr;
        w_wdata = i_wdata;
      end
      P_D: begin
        w_we    = d_we;
        w_be    = d_be;
        w_addr  = d_addr;
        w_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign w_gnt = (w_sel != P_NONE);
  assign w_inr = (w_addr < LIMIT);

  assign b_gnt = (w_sel == P_B);
  assign i_gnt = (w_sel == P_I);
  assign d_gnt = (w_sel == P_D);

  assign ram_en    = w_gnt & w_inr;
  assign ram_we    = w_we;
  assign ram_be    = w_be;
  assign ram_addr  = w_addr[ADDR_WIDTH-1:2];
  assign ram_wdata = w_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_port <= P_NONE;
      r_tag_we   <= 1'b0;
      r_tag_oor  <= 1'b0;
    end else begin
      r_tag_port <= w_sel;
      r_tag_we   <= w_we;
      r_tag_oor  <= ~w_inr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last_i <= 1'b0;
    else if (w_sel == P_I)
      r_last_i <= 1'b1;
    else if (w_sel == P_D)
      r_last_i <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_req && d_req && booted && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end

  assign o_conflict_cnt = r_cnt;

  // Responses are masked while rst is high so in-flight reads vanish
  assign w_rsp_rd  = ~rst & ~r_tag_we;
  assign w_rsp_err = ~rst & r_tag_oor;
  assign w_rsp_val = r_tag_oor ? '0 : ram_rdata;

  assign b_rvalid = w_rsp_rd & (r_tag_port == P_B);
  assign i_rvalid = w_rsp_rd & (r_tag_port == P_I);
  assign d_rvalid = w_rsp_rd & (r_tag_port == P_D);

  assign b_err = w_rsp_err & (r_tag_port == P_B);
  assign i_err = w_rsp_err & (r_tag_port == P_I);
  assign d_err = w_rsp_err & (r_tag_port == P_D);

  assign b_rdata = b_rvalid ? w_rsp_val : r_b_hold;
  assign i_rdata = i_rvalid ? w_rsp_val : r_i_hold;
  assign d_rdata = d_rvalid ? w_rsp_val : r_d_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_hold <= '0;
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (b_rvalid) r_b_hold <= w_rsp_val;
      if (i_rvalid) r_i_hold <= w_rsp_val;
      if (d_rvalid) r_d_hold <= w_rsp_val;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port program/data RAM between three requesters: the serial BIOS loader (B), CPU instruction fetch (I) and CPU load/store (D). While the CPU is held in BIOS mode (booted=0), only B may access RAM. After boot, only I and D may access RAM, under round-robin arbitration. The block sits between the BIOS, the CPU memory ports and the RAM macro, which has a fixed 1-cycle read latency.

Parameters:
ADDR_WIDTH, 32, byte-address width of every port.
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
MEM_BYTES, 16384, RAM size in bytes; addresses >= MEM_BYTES are out of range.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
booted  in  1  CPU-run mode; 0 = BIOS owns RAM, 1 = CPU owns RAM
{b,i,d}_req  in  1  access request; must be held with its attributes until gnt
{b,i,d}_we  in  1  1 = write, 0 = read
{b,i,d}_be  in  DATA_WIDTH/8  byte enables (writes only)
{b,i,d}_addr  in  ADDR_WIDTH  byte address
{b,i,d}_wdata  in  DATA_WIDTH  write data
{b,i,d}_gnt  out  1  request accepted this cycle
{b,i,d}_rvalid  out  1  read data valid (1-cycle pulse)
{b,i,d}_rdata  out  DATA_WIDTH  read data
{b,i,d}_err  out  1  out-of-range access response (pulse, same cycle as rvalid, or cycle after gnt for writes)
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write
ram_be  out  DATA_WIDTH/8  RAM byte enables
ram_addr  out  ADDR_WIDTH-2  RAM word address (byte addr >> 2)
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en & ~ram_we
o_conflict_cnt  out  16  saturating count of cycles with i_req & d_req both high and both eligible

Behaviour:
- Eligibility: B is eligible iff booted=0; I and D are eligible iff booted=1. An ineligible request gets no gnt and stays pending; it is never dropped.
- At most one gnt per cycle. Grant is combinational in the request cycle T.
- Winner selection when booted=1 and both I and D request: the port not granted most recently wins. The last-winner register updates on every I/D grant and resets to D, so I wins the first tie. A single requester wins immediately.
- RAM drive in cycle T: ram_en=1 iff a grant occurs and the address is in range; ram_we/be/addr/wdata are taken from the winner. With no grant: ram_en=0, ram_we=0, ram_be=0; other fields are don't-care.
- Read response: an owner tag (port, valid, out-of-range flag) is registered at T. At T+1 the owner's rvalid=1 and rdata=ram_rdata. Non-owners hold rvalid=0, and their rdata holds its last value.
- Out-of-range access (addr >= MEM_BYTES):
  - The request is still granted at T, but no RAM access is made.
  - For a read at T+1: rvalid=1, rdata=0, err=1.
  - For a write at T+1: err=1 only.
- Back-to-back: a new grant may occur at T+1 while the T response returns. Throughput is 1 access/cycle.
- booted toggling: gating applies from the same cycle. A response already in flight is still delivered to its tagged owner at the next cycle.
- o_conflict_cnt increments on each cycle with i_req & d_req & booted, and saturates at 16'hFFFF.
- Reset (rst=1 at a clock edge):
  - Clears the tag, last-winner (to D) and conflict count.
  - All gnt, rvalid, err and ram_en are 0 during reset. rdata resets to 0.
  - An in-flight read response is discarded when reset is asserted mid-operation.
- Sub-word writes: be is passed through unchanged. The arbiter performs no alignment checks; addr[1:0] is ignored.

Test Plan:
1. booted=0, b_req write addr 0x10, wdata 0xDEADBEEF, be 4'hF; i_req active the same cycle -> b_gnt=1, ram_en=1, ram_we=1, ram_addr=4; i_gnt=0 until booted=1.
2. booted=0, b read addr 0x10 with ram_rdata=0xDEADBEEF at T+1 -> b_rvalid=1 and b_rdata=0xDEADBEEF at T+1; i_rvalid=d_rvalid=0.
3. booted=1, i_req and d_req held 4 cycles -> grants I,D,I,D; each read's rvalid arrives at the correct port 1 cycle after its gnt; o_conflict_cnt=4.
4. booted=1, d read addr 0x4000 (MEM_BYTES=16384) -> d_gnt=1, ram_en=0; at next cycle d_rvalid=1, d_rdata=0, d_err=1.
5. i read granted at T, booted falls at T+1 -> i_rvalid delivered at T+1; no I/D grants afterwards; b_req is granted at T+1.
6. Force o_conflict_cnt to 16'hFFFE, then 3 conflict cycles -> count stays at 16'hFFFF. Assert rst mid-read -> no rvalid on any port, cnt=0.
